// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate-logic sweep sequencer.
// Holds the FSM state encoding and the golden truth-table maps for the gate unit.
// The golden maps are indexed by code {a,b,c}: bit i is the expected output for code i.
package gate_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } gs_state_e;

  localparam logic [7:0] GoldenX = 8'hA9;
  localparam logic [7:0] GoldenY = 8'hC0;

endpackage

// File: rtl/gate_sweep_ctrl.sv
// Sequencer for the 3-input/2-output gate-logic unit.
// Drives a code {a,b,c} onto the unit, waits SETTLE cycles, samples {y,x}, and
// compares the sample against the golden maps. Runs either one code or all eight.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start, mode, op_in  request, sweep select and single-mode code (sampled in IDLE)
//   abort               synchronous cancel back to IDLE, no done
//   drv_a/b/c           code bits 2/1/0 to the unit
//   res_x, res_y        unit outputs
//   busy, done          status; done pulses for one cycle on completion
//   x_map, y_map        captured outputs per code
//   mismatch, err_count result versus golden maps
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXP_X  = GoldenX,
  parameter logic [7:0]  EXP_Y  = GoldenY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [2:0] op_in,
  input  logic       abort,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_c,
  input  logic       res_x,
  input  logic       res_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_map,
  output logic [7:0] y_map,
  output logic       mismatch,
  output logic [3:0] err_count
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("gate_sweep_ctrl: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  gs_state_e  state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] code_q, code_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] x_map_q, x_map_d;
  logic [7:0] y_map_q, y_map_d;
  logic       mismatch_q, mismatch_d;
  logic [3:0] err_q, err_d;
  logic       sample_bad;

  assign sample_bad = ({res_y, res_x} != {EXP_Y[code_q], EXP_X[code_q]});

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    x_map_d    = x_map_q;
    y_map_d    = y_map_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          mode_d     = mode;
          code_d     = mode ? 3'd0 : op_in;
          cnt_d      = 4'd0;
          mismatch_d = 1'b0;
          err_d      = 4'd0;
          if (mode) begin
            x_map_d = 8'h00;
            y_map_d = 8'h00;
          end
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + 4'd1;
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (abort) begin
          // capture in the abort cycle is dropped
          state_d = StIdle;
        end else begin
          x_map_d[code_q] = res_x;
          y_map_d[code_q] = res_y;
          if (sample_bad) begin
            err_d      = err_q + 4'd1;
            mismatch_d = 1'b1;
          end
          if (mode_q && (code_q != 3'd7)) begin
            code_d  = code_q + 3'd1;
            cnt_d   = 4'd0;
            state_d = StDrive;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      code_q     <= 3'd0;
      cnt_q      <= 4'd0;
      x_map_q    <= 8'h00;
      y_map_q    <= 8'h00;
      mismatch_q <= 1'b0;
      err_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      x_map_q    <= x_map_d;
      y_map_q    <= y_map_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign drv_a     = code_q[2];
  assign drv_b     = code_q[1];
  assign drv_c     = code_q[0];
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign x_map     = x_map_q;
  assign y_map     = y_map_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: one instance with SETTLE=1 and one with SETTLE=3,
// each driving a behavioural gate unit built from the golden maps.
module tb_gate_sweep_ctrl;
  import gate_sweep_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start, start3, mode, abort;
  logic [2:0] op_in;
  logic       fault;

  logic       drv_a, drv_b, drv_c, res_x, res_y, busy, done, mismatch;
  logic [7:0] x_map, y_map;
  logic [3:0] err_count;
  logic       drv_a3, drv_b3, drv_c3, res_x3, res_y3, busy3, done3, mismatch3;
  logic [7:0] x_map3, y_map3;
  logic [3:0] err_count3;

  logic [7:0] gold_x = GoldenX;
  logic [7:0] gold_y = GoldenY;
  logic [2:0] code, code3;

  int n_checks = 0;
  int n_fail   = 0;

  assign code   = {drv_a, drv_b, drv_c};
  assign code3  = {drv_a3, drv_b3, drv_c3};
  // gate unit model, optional x stuck-at-0 on code 3
  assign res_x  = (fault && code == 3'd3) ? 1'b0 : gold_x[code];
  assign res_y  = gold_y[code];
  assign res_x3 = gold_x[code3];
  assign res_y3 = gold_y[code3];

  gate_sweep_ctrl #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .op_in(op_in), .abort(abort),
    .drv_a(drv_a), .drv_b(drv_b), .drv_c(drv_c), .res_x(res_x), .res_y(res_y),
    .busy(busy), .done(done), .x_map(x_map), .y_map(y_map), .mismatch(mismatch),
    .err_count(err_count)
  );

  gate_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode), .op_in(op_in), .abort(abort),
    .drv_a(drv_a3), .drv_b(drv_b3), .drv_c(drv_c3), .res_x(res_x3), .res_y(res_y3),
    .busy(busy3), .done(done3), .x_map(x_map3), .y_map(y_map3), .mismatch(mismatch3),
    .err_count(err_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic m, input logic [2:0] op);
    mode  = m;
    op_in = op;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({busy, done, code, mismatch, err_count} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 0", {busy, done, code, mismatch, err_count});
    end
    n_checks++;
    if ({x_map, y_map} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_maps: got %h required 0000", {x_map, y_map});
    end
    n_checks++;
    if ({busy3, done3, code3} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_dut3: got %b required 0", {busy3, done3, code3});
    end
  endtask

  task automatic test_sweep;
    kick(1'b1, 3'd0);
    for (int t = 0; t < 16; t++) begin
      n_checks++;
      if ({busy, done, code} !== {1'b1, 1'b0, 3'(t / 2)}) begin
        n_fail++;
        $display("FAIL sweep_step%0d: got busy/done/code %b required %b", t,
                 {busy, done, code}, {1'b1, 1'b0, 3'(t / 2)});
      end
      tick();
    end
    n_checks++;
    if ({done, x_map, y_map, mismatch, err_count} !== {1'b1, 8'hA9, 8'hC0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL sweep_result: got done=%b x=%h y=%h mm=%b err=%0d required 1 a9 c0 0 0",
               done, x_map, y_map, mismatch, err_count);
    end
    tick();
    n_checks++;
    if ({busy, done, code} !== {1'b0, 1'b0, 3'd7}) begin
      n_fail++;
      $display("FAIL sweep_after: got %b required 00111", {busy, done, code});
    end
  endtask

  task automatic test_single;
    kick(1'b0, 3'b110);
    n_checks++;
    if ({drv_a, drv_b, drv_c, busy, done} !== 5'b11010) begin
      n_fail++;
      $display("FAIL single_drive: got %b required 11010", {drv_a, drv_b, drv_c, busy, done});
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_done: got %b required 0", done);
    end
    tick();
    n_checks++;
    if ({done, x_map, y_map, mismatch} !== {1'b1, 8'hA9, 8'hC0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_result: got done=%b x=%h y=%h mm=%b required 1 a9 c0 0",
               done, x_map, y_map, mismatch);
    end
    tick();
  endtask

  task automatic test_fault;
    fault = 1'b1;
    kick(1'b1, 3'd0);
    repeat (16) tick();
    n_checks++;
    if ({done, x_map, y_map, mismatch, err_count} !== {1'b1, 8'hA1, 8'hC0, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL fault_sweep: got done=%b x=%h y=%h mm=%b err=%0d required 1 a1 c0 1 1",
               done, x_map, y_map, mismatch, err_count);
    end
    tick();
    // a clean single run on code 3 repairs that bit and clears the error status
    fault = 1'b0;
    kick(1'b0, 3'd3);
    repeat (2) tick();
    n_checks++;
    if ({done, x_map, y_map, mismatch, err_count} !== {1'b1, 8'hA9, 8'hC0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL single_repair: got done=%b x=%h y=%h mm=%b err=%0d required 1 a9 c0 0 0",
               done, x_map, y_map, mismatch, err_count);
    end
    tick();
  endtask

  task automatic test_abort;
    logic saw_done;
    // abort during the code-0 sample: that capture must not land
    kick(1'b1, 3'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, done, x_map, y_map} !== 18'd0) begin
      n_fail++;
      $display("FAIL abort_in_sample: got busy=%b done=%b x=%h y=%h required 0 0 00 00",
               busy, done, x_map, y_map);
    end
    // abort in the drive cycle right after the code-2 sample
    kick(1'b1, 3'd0);
    repeat (6) tick();
    n_checks++;
    if ({busy, code} !== 4'b1011) begin
      n_fail++;
      $display("FAIL abort_pre: got busy/code %b required 1011", {busy, code});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, done, x_map, y_map, mismatch, err_count} !== {1'b0, 1'b0, 8'h01, 8'h00, 5'd0}) begin
      n_fail++;
      $display("FAIL abort_in_drive: got busy=%b done=%b x=%h y=%h mm=%b err=%0d",
               busy, done, x_map, y_map, mismatch, err_count);
    end
    saw_done = 1'b0;
    repeat (20) begin
      tick();
      saw_done = saw_done | done | busy;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got busy/done activity %b required 0", saw_done);
    end
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    kick(1'b1, 3'd0);
    repeat (8) tick();
    n_checks++;
    if ({busy, code} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got busy/code %b required 1100", {busy, code});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, code, x_map, y_map, mismatch, err_count} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got busy=%b done=%b code=%0d x=%h y=%h mm=%b err=%0d",
               busy, done, code, x_map, y_map, mismatch, err_count);
    end
    saw_done = 1'b0;
    repeat (2) begin
      tick();
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      saw_done = saw_done | done | busy;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got activity %b required 0", saw_done);
    end
  endtask

  task automatic test_back_to_back;
    // start with abort in IDLE is dropped
    mode   = 1'b0;
    op_in  = 3'd5;
    start3 = 1'b1;
    abort  = 1'b1;
    tick();
    start3 = 1'b0;
    abort  = 1'b0;
    n_checks++;
    if (busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got busy=%b required 0", busy3);
    end
    start3 = 1'b1;
    tick();
    n_checks++;
    if ({busy3, done3, code3} !== 5'b10101) begin
      n_fail++;
      $display("FAIL s3_start: got %b required 10101", {busy3, done3, code3});
    end
    // restarts while busy, with a different mode/op, must not disturb the run
    for (int k = 1; k <= 3; k++) begin
      mode  = 1'b1;
      op_in = 3'd0;
      tick();
      n_checks++;
      if ({busy3, done3} !== 2'b10) begin
        n_fail++;
        $display("FAIL s3_busy_edge%0d: got busy/done %b required 10", k, {busy3, done3});
      end
    end
    start3 = 1'b0;
    mode   = 1'b0;
    tick();
    n_checks++;
    if ({done3, code3, x_map3, y_map3, mismatch3} !== {1'b1, 3'd5, 8'h20, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL s3_done: got done=%b code=%0d x=%h y=%h mm=%b required 1 5 20 00 0",
               done3, code3, x_map3, y_map3, mismatch3);
    end
    tick();
    n_checks++;
    if ({busy3, done3} !== 2'b00) begin
      n_fail++;
      $display("FAIL s3_no_queue: got busy/done %b required 00", {busy3, done3});
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 1'b0;
    op_in  = 3'd0;
    abort  = 1'b0;
    fault  = 1'b0;
    #3;
    test_reset();
    #10 rst_n = 1'b1;
    tick();
    test_sweep();
    test_single();
    test_fault();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer for the 3-input/2-output gate-logic unit (inputs a,b,c; outputs x,y). It drives the unit's inputs and samples its outputs after a settle time. It supports two modes: a single-code evaluation, or a full 8-code sweep that builds truth-table maps. Results are checked against golden maps, and a mismatch flag and error count are reported for on-board self-test.

Parameters:
SETTLE, 1, cycles the drive code is held before sampling (legal range 1..15)
EXP_X, 8'hA9, golden x map, bit i = x for code i = {a,b,c}
EXP_Y, 8'hC0, golden y map, bit i = y for code i

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
mode  input  1  0 = single code, 1 = full sweep; latched with start
op_in  input  3  code {a,b,c} for single mode; latched with start
abort  input  1  synchronous cancel, returns to IDLE without done
drv_a  output  1  to unit input a (code[2])
drv_b  output  1  to unit input b (code[1])
drv_c  output  1  to unit input c (code[0])
res_x  input  1  from unit output x
res_y  input  1  from unit output y
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion
x_map  output  8  captured x per code
y_map  output  8  captured y per code
mismatch  output  1  result differs from golden; valid from done, held until next start
err_count  output  4  number of codes whose {y,x} differ from golden (0..8)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; code=0; drv_*=0; busy=0; done=0; x_map=y_map=0; mismatch=0; err_count=0; settle counter=0. Reset mid-operation behaves identically, with no done pulse.
- drv_{a,b,c} are driven combinationally from the registered 3-bit code. They are stable for the whole DRIVE and SAMPLE period.
- States and transitions:
  - IDLE: on start=1, latch mode; set code = mode ? 0 : op_in; clear cnt, mismatch and err_count; if mode=1, also clear x_map and y_map; go to DRIVE. If start=0, stay in IDLE.
  - DRIVE: cnt increments each cycle; when cnt==SETTLE-1, go to SAMPLE.
  - SAMPLE: x_map[code]<=res_x; y_map[code]<=res_y; if {res_y,res_x} != {EXP_Y[code],EXP_X[code]}, err_count +1 and mismatch<=1.
    - Sweep mode with code!=7: code+1, cnt=0, go to DRIVE.
    - Otherwise: go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE. code holds its last value.
- Single mode only writes bit op_in of the maps; all other bits retain their previous values.
- Latency, start sampled at edge 0: done is high in cycle SETTLE+2 for single mode, and in cycle 8*(SETTLE+1)+1 for sweep. With SETTLE=1 these are cycles 3 and 17.
- start while busy is ignored and produces no queueing.
- start and abort together in IDLE: abort wins, state stays IDLE.
- abort=1 in DRIVE or SAMPLE: go to IDLE next edge with no done. Maps keep any bits already written. err_count and mismatch keep their partial values. The SAMPLE write in the abort cycle is suppressed.
- abort=1 in DONE: done still pulses that cycle (completion wins).
- err_count saturation is unnecessary because its maximum is 8, which fits in 4 bits.
- SETTLE=0 is illegal; the design guards it with a compile-time check.

Decomposition:
- Shared package/header holds the state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3) and the golden map constants 8'hA9/8'hC0, reused by the bench.
- No sub-module. A single FSM with counter is natural; the gate unit is instantiated alongside it in the parent, not inside this block.

Test Plan:
1. Reset then idle: rst_n low mid-sweep (code=4) -> all outputs 0 immediately (async), busy=0, no done pulse.
2. Sweep with correct unit, SETTLE=1: start=1, mode=1 -> drv code steps 0..7 every 2 cycles; done at cycle 17; x_map=8'hA9, y_map=8'hC0, mismatch=0, err_count=0.
3. Single mode, op_in=3'b110: -> drv_a=1, drv_b=1, drv_c=0; done at cycle 3; x_map[6]=0, y_map[6]=1, all other bits unchanged, mismatch=0.
4. Fault injection, bench forces res_x stuck-0 at code 3: sweep -> x_map=8'hA1, err_count=1, mismatch=1.
5. abort asserted in the cycle after the code-2 SAMPLE: -> IDLE next edge, no done; x_map bits 0..2 = 3'b001, bits 3..7 = 0.
6. start re-asserted while busy, plus start+abort together in IDLE -> ignored in both cases; a subsequent clean start completes normally with SETTLE=3 timing (single-mode done at cycle 5).
